// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity-mode constants and counter-width helpers
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} state_t;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  function automatic int sc_width(input int os);
    return (os > 1) ? $clog2(os) : 1;
  endfunction
  function automatic int bc_width(input int ws);
    return $clog2(ws + 1);
  endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: reset-to-1 multi-flop synchroniser (clk, rst_b async active-low, d raw in, q synchronised out)
module uart_sync #(
  parameter int stages = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);
  logic [stages-1:0] r;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) r <= '1;
    else r <= {r[stages-2:0], d};
  assign q = r[stages-1];
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver (serial_in -> rx_data/rx_valid/rx_ready, err_parity/err_frame/err_overrun pulses, busy)
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int word_size   = 8,
  parameter int oversample  = 8,
  parameter int sync_stages = 2
) (
  input  logic                 Sample_clk,
  input  logic                 rst_b,
  input  logic                 serial_in,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic [word_size-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 err_parity,
  output logic                 err_frame,
  output logic                 err_overrun,
  output logic                 busy
);
  localparam int SCW = sc_width(oversample);
  localparam int BCW = bc_width(word_size);
  localparam logic [SCW-1:0] SC_HALF = SCW'(oversample / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(oversample - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(word_size - 1);
  logic                 s_in;
  state_t               state, nxt;
  logic [SCW-1:0]       sc;
  logic [BCW-1:0]       bc;
  logic [word_size-1:0] shreg;
  logic                 perr, two_q;
  logic [1:0]           par_q;
  logic                 tick, par_on, frame_end, stop_bad, deliver;
  uart_sync #(.stages(sync_stages)) u_sync (
    .clk  (Sample_clk),
    .rst_b(rst_b),
    .d    (serial_in),
    .q    (s_in)
  );
  always_ff @(posedge Sample_clk or negedge rst_b)
    if (!rst_b) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (!s_in) nxt = START;
      START:   if (tick) nxt = s_in ? IDLE : DATA;
      DATA:    if (tick && bc == BC_LAST) nxt = par_on ? PARITY : STOP1;
      PARITY:  if (tick) nxt = STOP1;
      STOP1:   if (tick) nxt = !s_in ? BREAK : (two_q ? STOP2 : IDLE);
      STOP2:   if (tick) nxt = s_in ? IDLE : BREAK;
      BREAK:   if (s_in) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // start bit is checked at mid-bit; every later bit one full period on
  always_comb begin
    tick      = (state == START) ? (sc == SC_HALF) : (sc == SC_LAST);
    par_on    = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    frame_end = tick && s_in && ((state == STOP1 && !two_q) || state == STOP2);
    stop_bad  = tick && !s_in && (state == STOP1 || state == STOP2);
    deliver   = frame_end && !perr && !(rx_valid && !rx_ready);
  end
  assign busy = (state != IDLE);
  always_ff @(posedge Sample_clk or negedge rst_b)
    if (!rst_b) begin
      sc    <= '0;
      bc    <= '0;
      shreg <= '0;
      perr  <= 1'b0;
      par_q <= PAR_NONE;
      two_q <= 1'b0;
    end else begin
      sc <= (state == IDLE || state == BREAK || tick) ? '0 : sc + 1'b1;
      if (state == IDLE && !s_in) begin
        bc    <= '0;
        perr  <= 1'b0;
        par_q <= parity_mode;
        two_q <= two_stop;
      end
      if (state == DATA && tick) begin
        shreg <= {s_in, shreg[word_size-1:1]};
        bc    <= bc + 1'b1;
      end
      if (state == PARITY && tick) perr <= s_in != ((^shreg) ^ (par_q == PAR_ODD));
    end
  always_ff @(posedge Sample_clk or negedge rst_b)
    if (!rst_b) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_parity  <= frame_end && perr;
      err_frame   <= stop_bad;
      err_overrun <= frame_end && !perr && rx_valid && !rx_ready;
      if (deliver) rx_data <= shreg;
      rx_valid <= deliver || (rx_valid && !rx_ready);
    end
endmodule
